cam_lru: RTL

- Fully associative CAM with multiple registered lookup ports, self-allocating fill, key-based invalidate, flush, and true-LRU replacement.
- Successor to the basic two-entry CAM: the caller no longer picks the slot, and duplicates are suppressed in hardware.
- Intended for TLBs and miss-tracking tables, where a refill must choose a victim without external bookkeeping.

---
 rtl/cam_lru.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/cam_lru.sv
// Fully associative CAM with registered multi-port lookup, self-allocating fill,
// key invalidate, flush and true-LRU victim selection.
module cam_lru #(
  parameter int NUM_ENTRIES      = 8,
  parameter int KEY_WIDTH        = 32,
  parameter int NUM_LOOKUP_PORTS = 2,
  parameter int INDEX_WIDTH      = $clog2(NUM_ENTRIES)
) (
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic [NUM_LOOKUP_PORTS-1:0]             lookup_en,
  input  logic [NUM_LOOKUP_PORTS*KEY_WIDTH-1:0]   lookup_key,
  output logic [NUM_LOOKUP_PORTS-1:0]             lookup_hit,
  output logic [NUM_LOOKUP_PORTS*INDEX_WIDTH-1:0] lookup_idx,
  input  logic                                    fill_en,
  input  logic [KEY_WIDTH-1:0]                    fill_key,
  output logic                                    fill_done,
  output logic [INDEX_WIDTH-1:0]                  fill_idx,
  output logic                                    fill_evict,
  output logic [KEY_WIDTH-1:0]                    evict_key,
  input  logic                                    inval_en,
  input  logic [KEY_WIDTH-1:0]                    inval_key,
  input  logic                                    flush_en
);

  typedef logic [INDEX_WIDTH-1:0] idx_t;
  typedef logic [KEY_WIDTH-1:0]   key_t;

  logic [NUM_ENTRIES-1:0] valid;
  logic [NUM_ENTRIES-1:0] valid_next;
  key_t                   keys [NUM_ENTRIES];
  idx_t                   age  [NUM_ENTRIES];

  logic [NUM_ENTRIES-1:0] lk_match [NUM_LOOKUP_PORTS];
  logic [NUM_ENTRIES-1:0] fill_match;
  logic [NUM_ENTRIES-1:0] inval_match;

  logic fill_go, fill_hit, any_free, fill_replace, touch_en;
  idx_t free_idx, lru_idx, fill_slot, touch_idx, touch_age;

  // Match vectors are one-hot or zero, so OR-ing the indices of set bits
  // yields the matching index without a priority chain.
  function automatic idx_t encode(input logic [NUM_ENTRIES-1:0] v);
    idx_t r;
    r = '0;
    for (int i = 0; i < NUM_ENTRIES; i++)
      if (v[i]) r = r | idx_t'(i);
    return r;
  endfunction

  always_comb begin
    for (int p = 0; p < NUM_LOOKUP_PORTS; p++)
      for (int i = 0; i < NUM_ENTRIES; i++)
        lk_match[p][i] = valid[i] && (keys[i] == lookup_key[p*KEY_WIDTH +: KEY_WIDTH]);
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      fill_match[i]  = valid[i] && (keys[i] == fill_key);
      inval_match[i] = valid[i] && (keys[i] == inval_key);
    end
  end

  // NOTE: every variable assigned in this block gets a default first so no
  // path leaves it unassigned, which would infer a latch.
  always_comb begin
    any_free = ~&valid;
    free_idx = '0;
    for (int i = NUM_ENTRIES - 1; i >= 0; i--)
      if (!valid[i]) free_idx = idx_t'(i);
    lru_idx = '0;
    for (int i = 0; i < NUM_ENTRIES; i++)
      if (age[i] == idx_t'(NUM_ENTRIES - 1)) lru_idx = idx_t'(i);

    fill_go  = fill_en && !flush_en;
    fill_hit = |fill_match;
    if (fill_hit)      fill_slot = encode(fill_match);
    else if (any_free) fill_slot = free_idx;
    else               fill_slot = lru_idx;
    fill_replace = fill_go && !fill_hit && !any_free;

    touch_en  = fill_go || (lookup_en[0] && |lk_match[0]);
    touch_idx = fill_go ? fill_slot : encode(lk_match[0]);
    touch_age = age[touch_idx];

    // Inval clears before the fill sets, so a fill of the same key survives.
    valid_next = valid;
    if (flush_en) begin
      valid_next = '0;
    end else begin
      if (inval_en) valid_next = valid_next & ~inval_match;
      if (fill_go)  valid_next[fill_slot] = 1'b1;
    end
  end

  // NOTE: the key and age arrays are reset along with the valid bits because
  // the reset state of both is observable (age order picks victims, keys feed
  // evict_key), not just the valid flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid      <= '0;
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        keys[i] <= '0;
        age[i]  <= idx_t'(i);
      end
      lookup_hit <= '0;
      lookup_idx <= '0;
      fill_done  <= 1'b0;
      fill_idx   <= '0;
      fill_evict <= 1'b0;
      evict_key  <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every read in
      // this block sees the pre-edge value regardless of statement order.
      valid <= valid_next;
      if (fill_go) keys[fill_slot] <= fill_key;

      if (touch_en) begin
        for (int i = 0; i < NUM_ENTRIES; i++) begin
          if (idx_t'(i) == touch_idx)  age[i] <= '0;
          else if (age[i] < touch_age) age[i] <= age[i] + idx_t'(1);
        end
      end

      for (int p = 0; p < NUM_LOOKUP_PORTS; p++) begin
        lookup_hit[p] <= lookup_en[p] && |lk_match[p];
        lookup_idx[p*INDEX_WIDTH +: INDEX_WIDTH] <= lookup_en[p] ? encode(lk_match[p]) : '0;
      end

      fill_done  <= fill_go;
      fill_idx   <= fill_go ? fill_slot : '0;
      fill_evict <= fill_replace;
      evict_key  <= fill_replace ? keys[lru_idx] : '0;
    end
  end

  always @(posedge clk) begin
    if (!reset) begin
      for (int p = 0; p < NUM_LOOKUP_PORTS; p++)
        assert ($onehot0(lk_match[p]));
      assert ($onehot0(fill_match));
      assert ($onehot0(inval_match));
    end
  end

`ifdef SIMULATION
  always @(posedge clk) begin
    if (!reset) begin : perm_check
      logic [NUM_ENTRIES-1:0] seen;
      seen = '0;
      for (int i = 0; i < NUM_ENTRIES; i++) seen[age[i]] = 1'b1;
      assert (&seen);
    end
  end
`endif

endmodule
